// File: rtl/spi_komut_sirasi.sv
`timescale 1ns/1ps
// CPU-facing register file and word sequencer in front of the SPI engine.
// TX words are queued by the CPU, fed to the engine one per handshake, and RX words are queued back.
module spi_komut_sirasi #(
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 8
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic              bus_valid_i,
   input  logic              bus_we_i,
   input  logic [4:0]        bus_addr_i,
   input  logic [31:0]       bus_wdata_i,
   output logic              bus_ready_o,
   output logic [31:0]       bus_rdata_o,
   output logic              bus_rvalid_o,
   output logic              cmd_msb_first_o,
   output logic              cmd_cpha_o,
   output logic              cmd_cpol_o,
   output logic              cmd_hint_o,
   output logic              cmd_end_cs_o,
   output logic [15:0]       cmd_sck_div_o,
   output logic [1:0]        cmd_dir_o,
   output logic [DATA_W-1:0] cmd_data_o,
   output logic              cmd_valid_o,
   input  logic              cmd_ready_i,
   input  logic [DATA_W-1:0] recv_data_i,
   input  logic              recv_data_valid_i,
   output logic              irq_o
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FIN} state_t;

   state_t            state;
   logic [8:0]        rem_r;
   logic              end_cs_r;
   logic [1:0]        dir_r;
   logic              seen_busy_r;
   logic              busy_r;
   logic              cpol_r, cpha_r, msb_r, hint_r, irq_en_r;
   logic [15:0]       sck_div_r;
   logic              tx_ovf_r, done_r;

   logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
   logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
   logic [PW-1:0]     tx_rd, tx_wr, rx_rd, rx_wr;
   logic [CW-1:0]     tx_cnt, rx_cnt;

   logic [2:0]        reg_sel;
   logic              acc_wr, acc_rd, cmd_wr, hs, issue_ok;
   logic              tx_full, tx_empty, rx_full, rx_empty;
   logic              tx_push, tx_pop, tx_drop, rx_push, rx_pop;
   logic              unused_addr;

   assign reg_sel     = bus_addr_i[4:2];
   assign unused_addr = ^bus_addr_i[1:0];

   // A CMD write can only land while the sequencer is IDLE; it is held off otherwise.
   assign bus_ready_o = bus_valid_i &&
                        !(bus_we_i && reg_sel == 3'd4 && state != S_IDLE);
   assign acc_wr      = bus_ready_o && bus_we_i;
   assign acc_rd      = bus_ready_o && !bus_we_i;
   assign cmd_wr      = acc_wr && reg_sel == 3'd4;

   assign tx_full  = tx_cnt == FULL_CNT;
   assign tx_empty = tx_cnt == '0;
   assign rx_full  = rx_cnt == FULL_CNT;
   assign rx_empty = rx_cnt == '0;

   assign issue_ok = dir_r[1] ? !tx_empty : (dir_r[0] ? !rx_full : 1'b1);

   assign cmd_valid_o     = (state == S_ISSUE) && issue_ok;
   assign cmd_data_o      = (state == S_ISSUE && dir_r[1]) ? tx_mem[tx_rd] : '0;
   assign cmd_end_cs_o    = (state == S_ISSUE) && (rem_r == 9'd1) && end_cs_r;
   assign cmd_dir_o       = dir_r;
   assign cmd_cpol_o      = cpol_r;
   assign cmd_cpha_o      = cpha_r;
   assign cmd_msb_first_o = msb_r;
   assign cmd_hint_o      = hint_r;
   assign cmd_sck_div_o   = sck_div_r;
   assign irq_o           = done_r & irq_en_r;

   assign hs      = cmd_valid_o && cmd_ready_i;
   assign tx_push = acc_wr && reg_sel == 3'd3 && !tx_full;
   assign tx_drop = acc_wr && reg_sel == 3'd3 && tx_full;
   assign tx_pop  = hs && dir_r[1];
   assign rx_push = recv_data_valid_i && !rx_full;
   assign rx_pop  = acc_rd && reg_sel == 3'd2 && !rx_empty;

   // Engine settings are frozen for the whole command so every word uses the same mode.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         cpol_r    <= 1'b0;
         cpha_r    <= 1'b0;
         msb_r     <= 1'b0;
         hint_r    <= 1'b0;
         irq_en_r  <= 1'b0;
         sck_div_r <= '0;
      end else if (acc_wr && reg_sel == 3'd0 && !busy_r) begin
         cpol_r    <= bus_wdata_i[1];
         cpha_r    <= bus_wdata_i[2];
         msb_r     <= bus_wdata_i[3];
         hint_r    <= bus_wdata_i[4];
         irq_en_r  <= bus_wdata_i[5];
         sck_div_r <= bus_wdata_i[31:16];
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         tx_ovf_r <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         if (tx_drop)
            tx_ovf_r <= 1'b1;
         else if (acc_wr && reg_sel == 3'd1 && bus_wdata_i[5])
            tx_ovf_r <= 1'b0;
         if (state == S_FIN)
            done_r <= 1'b1;
         else if (acc_wr && reg_sel == 3'd1 && bus_wdata_i[6])
            done_r <= 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         tx_rd  <= '0;
         tx_wr  <= '0;
         tx_cnt <= '0;
         rx_rd  <= '0;
         rx_wr  <= '0;
         rx_cnt <= '0;
      end else begin
         if (tx_push) tx_wr <= tx_wr + PW'(1);
         if (tx_pop)  tx_rd <= tx_rd + PW'(1);
         if (tx_push && !tx_pop)      tx_cnt <= tx_cnt + CW'(1);
         else if (tx_pop && !tx_push) tx_cnt <= tx_cnt - CW'(1);
         if (rx_push) rx_wr <= rx_wr + PW'(1);
         if (rx_pop)  rx_rd <= rx_rd + PW'(1);
         if (rx_push && !rx_pop)      rx_cnt <= rx_cnt + CW'(1);
         else if (rx_pop && !rx_push) rx_cnt <= rx_cnt - CW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (tx_push) tx_mem[tx_wr] <= DATA_W'(bus_wdata_i);
      if (rx_push) rx_mem[rx_wr] <= recv_data_i;
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         bus_rvalid_o <= 1'b0;
         bus_rdata_o  <= '0;
      end else begin
         bus_rvalid_o <= acc_rd;
         if (acc_rd) begin
            case (reg_sel)
               3'd0:    bus_rdata_o <= {sck_div_r, 10'b0, irq_en_r, hint_r, msb_r,
                                        cpha_r, cpol_r, 1'b0};
               3'd1:    bus_rdata_o <= {25'b0, done_r, tx_ovf_r, busy_r, rx_empty,
                                        rx_full, tx_empty, tx_full};
               3'd2:    bus_rdata_o <= rx_empty ? 32'd0 : 32'(rx_mem[rx_rd]);
               default: bus_rdata_o <= '0;
            endcase
         end
      end
   end

   // A word is finished only after the engine has dropped ready and raised it again.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state       <= S_IDLE;
         rem_r       <= '0;
         end_cs_r    <= 1'b0;
         dir_r       <= '0;
         seen_busy_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (cmd_wr) begin
                  rem_r    <= bus_wdata_i[8:0];
                  end_cs_r <= bus_wdata_i[9];
                  dir_r    <= bus_wdata_i[11:10];
                  busy_r   <= 1'b1;
                  state    <= (bus_wdata_i[8:0] == 9'd0) ? S_FIN : S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (hs) begin
                  rem_r       <= rem_r - 9'd1;
                  seen_busy_r <= 1'b0;
                  state       <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (!cmd_ready_i)
                  seen_busy_r <= 1'b1;
               if (seen_busy_r && cmd_ready_i)
                  state <= (rem_r != 9'd0) ? S_ISSUE : S_FIN;
            end
            S_FIN: begin
               busy_r <= 1'b0;
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_komut_sirasi.sv
`timescale 1ns/1ps
// Self-checking bench for spi_komut_sirasi: queue-based model of the FIFOs and expected
// engine transactions, a small engine responder, and a per-cycle compare process.
module tb_spi_komut_sirasi;

   localparam int DEPTH = 8;

   logic        clk_i = 1'b0;
   logic        rstn_i = 1'b0;
   logic        bus_valid_i, bus_we_i;
   logic [4:0]  bus_addr_i;
   logic [31:0] bus_wdata_i;
   logic        bus_ready_o, bus_rvalid_o;
   logic [31:0] bus_rdata_o;
   logic        cmd_msb_first_o, cmd_cpha_o, cmd_cpol_o, cmd_hint_o, cmd_end_cs_o;
   logic [15:0] cmd_sck_div_o;
   logic [1:0]  cmd_dir_o;
   logic [31:0] cmd_data_o;
   logic        cmd_valid_o, cmd_ready_i;
   logic [31:0] recv_data_i;
   logic        recv_data_valid_i;
   logic        irq_o;

   always #5 clk_i = ~clk_i;

   spi_komut_sirasi #(.DATA_W(32), .FIFO_DEPTH(DEPTH)) dut (
      .clk_i(clk_i), .rstn_i(rstn_i),
      .bus_valid_i(bus_valid_i), .bus_we_i(bus_we_i), .bus_addr_i(bus_addr_i),
      .bus_wdata_i(bus_wdata_i), .bus_ready_o(bus_ready_o), .bus_rdata_o(bus_rdata_o),
      .bus_rvalid_o(bus_rvalid_o),
      .cmd_msb_first_o(cmd_msb_first_o), .cmd_cpha_o(cmd_cpha_o), .cmd_cpol_o(cmd_cpol_o),
      .cmd_hint_o(cmd_hint_o), .cmd_end_cs_o(cmd_end_cs_o), .cmd_sck_div_o(cmd_sck_div_o),
      .cmd_dir_o(cmd_dir_o), .cmd_data_o(cmd_data_o), .cmd_valid_o(cmd_valid_o),
      .cmd_ready_i(cmd_ready_i), .recv_data_i(recv_data_i),
      .recv_data_valid_i(recv_data_valid_i), .irq_o(irq_o)
   );

   typedef struct {
      logic [31:0] data;
      logic        endCs;
      logic [1:0]  dir;
   } txn_t;

   txn_t        expQ[$];
   logic [31:0] txModel[$];
   logic [31:0] rxModel[$];
   logic [31:0] respQ[$];
   logic [31:0] hsLog[$];
   logic        hsEndLog[$];
   bit          hsPending = 1'b0;
   int          hsCount = 0;
   int          errCount = 0;
   int          checkCount = 0;
   logic [15:0] mSckDiv = '0;
   logic        mCpol = 1'b0, mCpha = 1'b0, mMsb = 1'b0, mHint = 1'b0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checkCount++;
      if (act !== exp) begin
         errCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic timeoutFail(input string name);
      checkCount++;
      errCount++;
      $display("[TB] FAIL %s: timed out waiting for the DUT", name);
   endtask

   // One bus access; called at a negedge, returns at the negedge after acceptance.
   task automatic applyStimulus(input logic we, input logic [4:0] addr,
                                input logic [31:0] wdata, output logic [31:0] rdata);
      int n;
      n = 0;
      bus_valid_i = 1'b1;
      bus_we_i    = we;
      bus_addr_i  = addr;
      bus_wdata_i = wdata;
      #1;
      while (!bus_ready_o && n < 500) begin
         @(negedge clk_i);
         #1;
         n++;
      end
      if (!bus_ready_o) begin
         timeoutFail("bus_accept");
         bus_valid_i = 1'b0;
         rdata = '0;
         return;
      end
      @(negedge clk_i);
      bus_valid_i = 1'b0;
      bus_we_i    = 1'b0;
      rdata = bus_rdata_o;
      if (!we) checkOutput("read_rvalid", 32'(bus_rvalid_o), 32'd1);
   endtask

   task automatic regWrite(input logic [4:0] addr, input logic [31:0] data);
      logic [31:0] dummy;
      applyStimulus(1'b1, addr, data, dummy);
   endtask

   task automatic regRead(input logic [4:0] addr, output logic [31:0] data);
      applyStimulus(1'b0, addr, 32'd0, data);
   endtask

   task automatic setCtrl(input logic [31:0] v);
      regWrite(5'h00, v);
      mSckDiv = v[31:16];
      mCpol = v[1];
      mCpha = v[2];
      mMsb  = v[3];
      mHint = v[4];
   endtask

   task automatic pushWord(input logic [31:0] w);
      regWrite(5'h0C, w);
      if (txModel.size() < DEPTH) txModel.push_back(w);
   endtask

   task automatic readRdata(input string name, input logic [31:0] lit);
      logic [31:0] v, e;
      regRead(5'h08, v);
      e = (rxModel.size() > 0) ? rxModel.pop_front() : 32'd0;
      checkOutput({name, "_model"}, v, e);
      checkOutput({name, "_lit"}, v, lit);
   endtask

   task automatic checkStatus(input string name, input logic [31:0] lit);
      logic [31:0] v;
      regRead(5'h04, v);
      checkOutput(name, v, lit);
   endtask

   // Builds the engine transactions a command must produce, then writes CMD.
   task automatic issueCmd(input logic [8:0] len, input logic endCs, input logic [1:0] dir);
      txn_t t;
      for (int i = 0; i < int'(len); i++) begin
         t.data  = (dir[1] && txModel.size() > 0) ? txModel.pop_front() : 32'd0;
         t.endCs = (i == int'(len) - 1) ? endCs : 1'b0;
         t.dir   = dir;
         expQ.push_back(t);
      end
      regWrite(5'h10, {20'b0, dir, endCs, len});
   endtask

   task automatic waitIdle(input string name);
      logic [31:0] s;
      int n;
      n = 0;
      regRead(5'h04, s);
      while (s[4] && n < 200) begin
         regRead(5'h04, s);
         n++;
      end
      checkOutput({name, "_idle"}, 32'(s[4]), 32'd0);
   endtask

   // Engine responder: accept, drop ready for two cycles, then return a word if receiving.
   initial begin
      txn_t t;
      logic [1:0] d;
      cmd_ready_i = 1'b1;
      recv_data_valid_i = 1'b0;
      recv_data_i = '0;
      forever begin
         @(negedge clk_i);
         #2;
         if (cmd_valid_o && cmd_ready_i) begin
            d = cmd_dir_o;
            hsPending = 1'b1;
            hsCount++;
            hsLog.push_back(cmd_data_o);
            hsEndLog.push_back(cmd_end_cs_o);
            if (expQ.size() == 0) begin
               timeoutFail("unexpected_engine_txn");
            end else begin
               t = expQ.pop_front();
               checkOutput("hs_data", cmd_data_o, t.data);
               checkOutput("hs_end_cs", 32'(cmd_end_cs_o), 32'(t.endCs));
               checkOutput("hs_dir", 32'(cmd_dir_o), 32'(t.dir));
            end
            @(posedge clk_i);
            #1;
            hsPending = 1'b0;
            cmd_ready_i = 1'b0;
            @(posedge clk_i);
            @(posedge clk_i);
            #1;
            cmd_ready_i = 1'b1;
            if (d[0]) begin
               recv_data_valid_i = 1'b1;
               recv_data_i = (respQ.size() > 0) ? respQ.pop_front() : 32'd0;
               rxModel.push_back(recv_data_i);
            end
            @(posedge clk_i);
            #1;
            recv_data_valid_i = 1'b0;
         end
      end
   end

   // Per-cycle compare against the model while out of reset.
   initial begin
      forever begin
         @(negedge clk_i);
         #3;
         if (rstn_i && !hsPending) begin
            if (expQ.size() == 0) begin
               checkOutput("no_valid_when_nothing_owed", 32'(cmd_valid_o), 32'd0);
            end else begin
               if (expQ[0].dir == 2'b01 && rxModel.size() >= DEPTH)
                  checkOutput("rx_full_holds_issue", 32'(cmd_valid_o), 32'd0);
               if (cmd_valid_o) begin
                  checkOutput("cyc_ctrl_fields",
                              32'({cmd_sck_div_o, cmd_cpol_o, cmd_cpha_o, cmd_msb_first_o, cmd_hint_o}),
                              32'({mSckDiv, mCpol, mCpha, mMsb, mHint}));
                  checkOutput("cyc_dir", 32'(cmd_dir_o), 32'(expQ[0].dir));
                  checkOutput("cyc_data", cmd_data_o, expQ[0].data);
                  checkOutput("cyc_end_cs", 32'(cmd_end_cs_o), 32'(expQ[0].endCs));
               end
            end
         end
      end
   end

   initial begin
      #600000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] v;
      int hc, n;
      bus_valid_i = 1'b0;
      bus_we_i    = 1'b0;
      bus_addr_i  = '0;
      bus_wdata_i = '0;
      rstn_i      = 1'b0;
      repeat (2) @(negedge clk_i);
      #1;
      checkOutput("rst_cmd_valid", 32'(cmd_valid_o), 32'd0);
      checkOutput("rst_irq", 32'(irq_o), 32'd0);
      checkOutput("rst_rvalid", 32'(bus_rvalid_o), 32'd0);
      checkOutput("rst_rdata", bus_rdata_o, 32'd0);
      checkOutput("rst_cmd_data", cmd_data_o, 32'd0);
      checkOutput("rst_cmd_fields",
                  32'({cmd_sck_div_o, cmd_dir_o, cmd_cpol_o, cmd_cpha_o, cmd_msb_first_o,
                       cmd_hint_o, cmd_end_cs_o}), 32'd0);
      bus_valid_i = 1'b1;
      #1;
      checkOutput("rst_ready_follows_hi", 32'(bus_ready_o), 32'd1);
      bus_valid_i = 1'b0;
      #1;
      checkOutput("rst_ready_follows_lo", 32'(bus_ready_o), 32'd0);
      @(negedge clk_i);
      rstn_i = 1'b1;

      $display("[TB] two-word send");
      checkStatus("status_after_reset", 32'h0000_000A);
      setCtrl(32'h0020_0008);
      regRead(5'h00, v);
      checkOutput("ctrl_readback", v, 32'h0020_0008);
      pushWord(32'hA5A5_0001);
      pushWord(32'h1234_5678);
      issueCmd(9'd2, 1'b1, 2'b10);
      waitIdle("send2");
      checkOutput("send2_hs_count", 32'(hsCount), 32'd2);
      checkOutput("send2_word0", hsLog[0], 32'hA5A5_0001);
      checkOutput("send2_word1", hsLog[1], 32'h1234_5678);
      checkOutput("send2_end_cs0", 32'(hsEndLog[0]), 32'd0);
      checkOutput("send2_end_cs1", 32'(hsEndLog[1]), 32'd1);
      checkStatus("send2_status", 32'h0000_004A);
      regWrite(5'h04, 32'h40);
      checkStatus("done_cleared", 32'h0000_000A);

      $display("[TB] three-word receive");
      respQ = '{32'h11, 32'h22, 32'h33};
      issueCmd(9'd3, 1'b0, 2'b01);
      waitIdle("recv3");
      checkStatus("recv3_status", 32'h0000_0042);
      readRdata("recv3_r0", 32'h11);
      readRdata("recv3_r1", 32'h22);
      readRdata("recv3_r2", 32'h33);
      readRdata("recv3_empty_read", 32'h0);
      checkStatus("recv3_status_empty", 32'h0000_004A);
      regWrite(5'h04, 32'h40);

      $display("[TB] receive blocked by full RX FIFO");
      for (int i = 0; i < DEPTH; i++) respQ.push_back(32'h100 + i);
      issueCmd(9'(DEPTH), 1'b0, 2'b01);
      waitIdle("rxfill");
      checkStatus("rxfill_status", 32'h0000_0046);
      regWrite(5'h04, 32'h40);
      respQ.push_back(32'h77);
      hc = hsCount;
      issueCmd(9'd1, 1'b1, 2'b01);
      repeat (10) @(negedge clk_i);
      checkOutput("rxfull_no_issue", 32'(hsCount - hc), 32'd0);
      checkStatus("rxfull_busy_status", 32'h0000_0016);
      readRdata("rxfull_pop", 32'h100);
      waitIdle("rxfull_resume");
      checkOutput("rxfull_issued_after_pop", 32'(hsCount - hc), 32'd1);
      for (int i = 0; i < DEPTH; i++)
         readRdata("rx_drain", (i < DEPTH - 1) ? 32'h101 + i : 32'h77);
      checkStatus("rx_drain_status", 32'h0000_004A);
      regWrite(5'h04, 32'h40);

      $display("[TB] TX overflow and wrap");
      for (int i = 0; i <= DEPTH; i++) pushWord(32'hC000_0000 + i);
      checkStatus("tx_ovf_status", 32'h0000_0029);
      regWrite(5'h04, 32'h20);
      checkStatus("tx_ovf_cleared", 32'h0000_0009);
      issueCmd(9'(DEPTH), 1'b0, 2'b10);
      waitIdle("tx_drain");
      checkOutput("tx_drain_last_word", hsLog[hsLog.size() - 1], 32'hC000_0007);
      checkStatus("tx_drain_status", 32'h0000_004A);
      regWrite(5'h04, 32'h40);

      $display("[TB] CMD write while busy");
      pushWord(32'hD00D_0001);
      hc = hsCount;
      issueCmd(9'd1, 1'b1, 2'b10);
      bus_valid_i = 1'b1;
      bus_we_i    = 1'b1;
      bus_addr_i  = 5'h10;
      bus_wdata_i = 32'h0;
      #1;
      checkOutput("cmd_stall_ready", 32'(bus_ready_o), 32'd0);
      issueCmd(9'd0, 1'b0, 2'b00);
      checkOutput("stall_until_first_done", 32'(hsCount - hc), 32'd1);
      waitIdle("stall");
      checkStatus("stall_status", 32'h0000_004A);
      regWrite(5'h04, 32'h40);

      $display("[TB] zero-length command and interrupt");
      setCtrl(32'h0020_0028);
      issueCmd(9'd0, 1'b0, 2'b00);
      #1;
      checkOutput("len0_irq_not_yet", 32'(irq_o), 32'd0);
      @(negedge clk_i);
      #1;
      checkOutput("len0_irq_set", 32'(irq_o), 32'd1);
      checkStatus("len0_status", 32'h0000_004A);
      regWrite(5'h04, 32'h40);
      #1;
      checkOutput("irq_cleared", 32'(irq_o), 32'd0);
      setCtrl(32'h0020_0008);
      issueCmd(9'd0, 1'b0, 2'b00);
      repeat (3) @(negedge clk_i);
      #1;
      checkOutput("len0_irq_masked", 32'(irq_o), 32'd0);
      checkStatus("len0_masked_status", 32'h0000_004A);
      regWrite(5'h04, 32'h40);

      $display("[TB] reset during WAIT");
      pushWord(32'hE000_0001);
      pushWord(32'hE000_0002);
      hc = hsCount;
      issueCmd(9'd2, 1'b1, 2'b10);
      n = 0;
      while (hsCount == hc && n < 100) begin
         @(negedge clk_i);
         n++;
      end
      if (hsCount == hc) timeoutFail("reset_wait_handshake");
      rstn_i = 1'b0;
      #1;
      checkOutput("midrst_cmd_valid", 32'(cmd_valid_o), 32'd0);
      checkOutput("midrst_cmd_data", cmd_data_o, 32'd0);
      checkOutput("midrst_end_cs", 32'(cmd_end_cs_o), 32'd0);
      checkOutput("midrst_sck_div", 32'(cmd_sck_div_o), 32'd0);
      expQ.delete();
      txModel.delete();
      rxModel.delete();
      mSckDiv = '0;
      mCpol = 1'b0;
      mCpha = 1'b0;
      mMsb  = 1'b0;
      mHint = 1'b0;
      @(negedge clk_i);
      rstn_i = 1'b1;
      checkStatus("midrst_status", 32'h0000_000A);
      regRead(5'h00, v);
      checkOutput("midrst_ctrl", v, 32'h0);
      pushWord(32'hBEEF_0001);
      issueCmd(9'd1, 1'b1, 2'b10);
      waitIdle("post_reset");
      checkOutput("post_reset_word", hsLog[hsLog.size() - 1], 32'hBEEF_0001);
      checkOutput("post_reset_end_cs", 32'(hsEndLog[hsEndLog.size() - 1]), 32'd1);
      checkStatus("post_reset_status", 32'h0000_004A);

      repeat (5) @(negedge clk_i);
      checkOutput("expected_txns_drained", 32'(expQ.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule

// File: doc/spi_komut_sirasi.md
Name: spi_komut_sirasi

Overview:
- Memory-mapped front-end and word sequencer that sits directly upstream of the SPI engine (spi_birimi).
- The CPU writes control settings, pushes TX words into a FIFO and issues a multi-word command; the block feeds the engine one `SPI_TXN_SIZE-bit word at a time over its cmd_* handshake.
- Received words are collected into an RX FIFO that the CPU reads back.

Parameters:
- DATA_W, `SPI_TXN_SIZE (32): word width; must equal the engine transaction size.
- FIFO_DEPTH, 8: TX and RX FIFO depth; power of two, at least 2.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- bus_valid_i  in  1  CPU access request
- bus_we_i  in  1  1 = write, 0 = read
- bus_addr_i  in  5  byte address; bits [4:2] select the register
- bus_wdata_i  in  32  write data
- bus_ready_o  out  1  access accepted this cycle
- bus_rdata_o  out  32  read data, registered
- bus_rvalid_o  out  1  read data valid, one cycle after acceptance
- cmd_msb_first_o, cmd_cpha_o, cmd_cpol_o, cmd_hint_o, cmd_end_cs_o  out  1 each  to engine
- cmd_sck_div_o  out  16  to engine
- cmd_dir_o  out  2  to engine
- cmd_data_o  out  DATA_W  to engine
- cmd_valid_o  out  1  to engine
- cmd_ready_i  in  1  from engine
- recv_data_i  in  DATA_W  from engine
- recv_data_valid_i  in  1  from engine
- irq_o  out  1  done interrupt, level

Behaviour:
- Registers:
  - 0x00 CTRL (RW): [1] cpol, [2] cpha, [3] msb_first, [4] hint, [5] irq_en, [31:16] sck_div. Reset value 0x0000_0000.
  - 0x04 STATUS: [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty, [4] busy, [5] tx_ovf (sticky), [6] done (sticky). Writing 1 to bit 5 or bit 6 clears that bit.
  - 0x08 RDATA (RO): a read pops the RX FIFO. If the FIFO is empty the read returns 0 and nothing is popped.
  - 0x0C WDATA (WO): a write pushes the TX FIFO. If the FIFO is full the word is dropped and tx_ovf is set.
  - 0x10 CMD (WO): [8:0] len in words, [9] end_cs, [11:10] dir. A write starts a command.
  - Other addresses: reads return 0, writes are ignored.
- Bus handshake:
  - bus_ready_o = bus_valid_i, except for a CMD write while busy, where it stays 0 (stall) until the sequencer is IDLE.
  - Reads: bus_rvalid_o pulses and bus_rdata_o updates on the cycle after acceptance.
- Sequencer FSM, states IDLE / ISSUE / WAIT / FIN:
  - IDLE: on an accepted CMD write, latch len/end_cs/dir into rem_r/end_cs_r/dir_r. busy = 1. If len = 0, go to FIN; otherwise go to ISSUE.
  - ISSUE: drive cmd_valid_o = 1 only when:
    - send (dir[1] = 1) requires tx not empty;
    - receive (dir = 2'b01) requires rx not full, so the RX FIFO never overflows;
    - dir = 2'b00 issues with no condition.
  - ISSUE, engine fields while waiting: cmd_data_o is the TX FIFO head for send, otherwise 0. The other cmd_* fields come from CTRL. cmd_end_cs_o = end_cs_r when rem_r = 1, otherwise 0, so CS stays low between words.
  - ISSUE, handshake: on cmd_valid_o && cmd_ready_i, pop TX (send only), decrement rem_r, clear seen_busy_r, go to WAIT.
  - WAIT: set seen_busy_r when cmd_ready_i = 0. Exit when seen_busy_r && cmd_ready_i: go to ISSUE if rem_r != 0, otherwise FIN.
  - FIN: set done, clear busy, go to IDLE. One cycle.
- CTRL must not change while busy; a CTRL write while busy is accepted and ignored.
- RX: every recv_data_valid_i pulse pushes recv_data_i, in any state. A push and a pop in the same cycle are both performed and the count is unchanged.
- FIFOs: circular pointers with log2(FIFO_DEPTH)+1-bit count; wrap-around is transparent. A WDATA push on the same cycle as a sequencer pop is allowed.
- irq_o = done & irq_en, combinational from registers.
- Reset, asynchronous, any time including mid-command:
  - FSM goes to IDLE, FIFOs are emptied, sticky bits are cleared.
  - All outputs 0, except bus_ready_o, which follows bus_valid_i.

Test Plan:
- Write CTRL = 0x0020_0008, push 0xA5A5_0001 and 0x1234_5678, then CMD len=2 dir=2'b10 end_cs=1 → two engine handshakes in that order, cmd_end_cs_o = 0 then 1, done = 1, tx_empty = 1.
- CMD len=3 dir=2'b01 while the model engine returns 0x11, 0x22, 0x33 → rx holds 3 words; three RDATA reads return 0x11, 0x22, 0x33; a fourth read returns 0 and rx_empty = 1.
- With the RX FIFO pre-filled to FIFO_DEPTH, a CMD len=1 dir=2'b01 stays in ISSUE with cmd_valid_o = 0 until one RDATA pop, then issues.
- Nine WDATA writes with FIFO_DEPTH = 8 → ninth word dropped, tx_ovf = 1; write STATUS = 0x20 → tx_ovf = 0.
- CMD write while busy → bus_ready_o low until FIN. CMD len=0 → done set two cycles later with no cmd_valid_o; irq_o = 1 only when irq_en = 1.
- Assert rstn_i mid-transfer during WAIT → same cycle, cmd_valid_o = 0, busy = 0, FIFOs empty; a subsequent len=1 send completes normally.
